// File: rtl/semaphore_channel.sv
// Bit-wide FIFO semaphore/mailbox between two cores; acts on rising edges of held CPU handshakes.
// Optional sticky overflow/underflow flags with err_clear are enabled by defining SEMA_ERR_FLAGS_EN.
module semaphore_channel #(
  parameter  int DEPTH = 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
`ifdef SEMA_ERR_FLAGS_EN
  input  logic             err_clear,
  output logic             sema_overflow,
  output logic             sema_underflow,
`endif
  input  logic             prod_sema_write,
  input  logic             prod_sema_data,
  output logic             prod_sema_is_empty,
  input  logic             cons_sema_ready,
  output logic             cons_sema_valid,
  output logic             cons_sema_data,
  output logic [CNT_W-1:0] occupancy
);

  // DEPTH=1 still gets a 1-bit pointer; it is pinned at 0 by the wrap compare.
  localparam int                PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                MEM_N   = 1 << PTR_W;
  localparam logic [PTR_W-1:0]  PTR_MAX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL    = CNT_W'(DEPTH);

  logic [MEM_N-1:0] mem;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             wr_q, rdy_q;
  logic             push_req, pop_req, can_push, can_pop, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  assign push_req = prod_sema_write & ~wr_q;
  assign pop_req  = cons_sema_ready & ~rdy_q;
  assign can_push = occupancy < FULL;
  assign can_pop  = occupancy != '0;
  assign push     = push_req & can_push;
  assign pop      = pop_req & can_pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q      <= 1'b0;
      rdy_q     <= 1'b0;
      mem       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      wr_q  <= prod_sema_write;
      rdy_q <= cons_sema_ready;
      if (push) begin
        mem[wr_ptr] <= prod_sema_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      // Simultaneous push+pop leaves the count unchanged.
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

`ifdef SEMA_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sema_overflow  <= 1'b0;
      sema_underflow <= 1'b0;
    end else if (err_clear) begin
      sema_overflow  <= 1'b0;
      sema_underflow <= 1'b0;
    end else begin
      if (push_req & ~can_push) sema_overflow  <= 1'b1;
      if (pop_req & ~can_pop)   sema_underflow <= 1'b1;
    end
  end
`endif

  assign cons_sema_valid    = occupancy != '0;
  assign cons_sema_data     = mem[rd_ptr];
  assign prod_sema_is_empty = occupancy < FULL;

endmodule

// File: tb/tb_semaphore_channel.sv
// Directed bench for semaphore_channel: a DEPTH=1 and a DEPTH=4 instance driven side by side.
module tb_semaphore_channel;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       w1 = 0, d1 = 0, r1 = 0;
  logic       w4 = 0, d4 = 0, r4 = 0;
  logic       e1, v1, q1, e4, v4, q4;
  logic [0:0] occ1;
  logic [2:0] occ4;
  int         passed = 0, total = 0;
  logic       model_q[$];
  logic       exp_head;
`ifdef SEMA_ERR_FLAGS_EN
  logic       clr1 = 0, clr4 = 0;
  logic       ovf1, unf1, ovf4, unf4;
`endif

  always #5 clk = ~clk;

  semaphore_channel #(.DEPTH(1)) dut1 (
    .clk(clk), .rstn(rstn),
`ifdef SEMA_ERR_FLAGS_EN
    .err_clear(clr1), .sema_overflow(ovf1), .sema_underflow(unf1),
`endif
    .prod_sema_write(w1), .prod_sema_data(d1), .prod_sema_is_empty(e1),
    .cons_sema_ready(r1), .cons_sema_valid(v1), .cons_sema_data(q1), .occupancy(occ1)
  );

  semaphore_channel #(.DEPTH(4)) dut4 (
    .clk(clk), .rstn(rstn),
`ifdef SEMA_ERR_FLAGS_EN
    .err_clear(clr4), .sema_overflow(ovf4), .sema_underflow(unf4),
`endif
    .prod_sema_write(w4), .prod_sema_data(d4), .prod_sema_is_empty(e4),
    .cons_sema_ready(r4), .cons_sema_valid(v4), .cons_sema_data(q4), .occupancy(occ4)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance past the next rising edge and settle away from it.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push4(input logic d);
    w4 = 1; d4 = d; tick(); w4 = 0; tick();
  endtask

  task automatic pop4();
    r4 = 1; tick(); r4 = 0; tick();
  endtask

  task automatic chk4(input string tag, input logic [2:0] occ, input logic v, input logic q);
    chk({tag, "_occ"}, 8'(occ4), 8'(occ));
    chk({tag, "_valid"}, 8'(v4), 8'(v));
    chk({tag, "_empty"}, 8'(e4), 8'(occ < 3'd4));
    if (v) chk({tag, "_data"}, 8'(q4), 8'(q));
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst1_occ", 8'(occ1), 8'd0);
    chk("rst1_valid", 8'(v1), 8'd0);
    chk("rst1_data", 8'(q1), 8'd0);
    chk("rst1_empty", 8'(e1), 8'd1);
    chk4("rst4", 3'd0, 1'b0, 1'b0);
    chk("rst4_data", 8'(q4), 8'd0);
`ifdef SEMA_ERR_FLAGS_EN
    chk("rst_ovf", 8'(ovf4), 8'd0);
    chk("rst_unf", 8'(unf4), 8'd0);
`endif
    @(posedge clk); #2;
    rstn = 1;
    tick();

    // DEPTH=1: held write produces exactly one push
    w1 = 1; d1 = 1;
    tick();
    chk("d1_push_valid", 8'(v1), 8'd1);
    chk("d1_push_data", 8'(q1), 8'd1);
    chk("d1_push_occ", 8'(occ1), 8'd1);
    chk("d1_push_empty", 8'(e1), 8'd0);
    tick(4);
    chk("d1_hold_occ", 8'(occ1), 8'd1);
    w1 = 0;
    tick();
    // Held ready produces exactly one pop
    r1 = 1;
    tick();
    chk("d1_pop_valid", 8'(v1), 8'd0);
    chk("d1_pop_occ", 8'(occ1), 8'd0);
    chk("d1_pop_empty", 8'(e1), 8'd1);
    tick(5);
    chk("d1_hold_rdy_occ", 8'(occ1), 8'd0);
`ifdef SEMA_ERR_FLAGS_EN
    chk("d1_no_unf", 8'(unf1), 8'd0);
`endif
    r1 = 0;
    tick();

    // DEPTH=4: fill 1,0,1,1 then overflow
    push4(1); chk4("fill1", 3'd1, 1'b1, 1'b1);
    push4(0); chk4("fill2", 3'd2, 1'b1, 1'b1);
    push4(1); chk4("fill3", 3'd3, 1'b1, 1'b1);
    push4(1); chk4("fill4", 3'd4, 1'b1, 1'b1);
    push4(0); chk4("ovf_drop", 3'd4, 1'b1, 1'b1);
`ifdef SEMA_ERR_FLAGS_EN
    chk("ovf_set", 8'(ovf4), 8'd1);
    tick(2);
    chk("ovf_sticky", 8'(ovf4), 8'd1);
    clr4 = 1; tick(); clr4 = 0;
    chk("ovf_clear", 8'(ovf4), 8'd0);
`endif
    pop4(); chk4("drain1", 3'd3, 1'b1, 1'b0);
    pop4(); chk4("drain2", 3'd2, 1'b1, 1'b1);
    pop4(); chk4("drain3", 3'd1, 1'b1, 1'b1);
    pop4(); chk4("drain4", 3'd0, 1'b0, 1'b0);

    // Simultaneous push+pop at occupancy 2, six rounds to wrap pointers
    push4(1); push4(0);
    model_q = '{1'b1, 1'b0};
    foreach (model_q[i]) begin end
    for (int i = 0; i < 6; i++) begin
      logic [5:0] pat;
      pat = 6'b001011;
      w4 = 1; r4 = 1; d4 = pat[i];
      model_q.push_back(pat[i]);
      void'(model_q.pop_front());
      tick();
      w4 = 0; r4 = 0;
      tick();
      exp_head = model_q[0];
      chk4($sformatf("sim%0d", i), 3'd2, 1'b1, exp_head);
    end
    pop4(); chk4("sim_drain1", 3'd1, 1'b1, model_q[1]);
    pop4(); chk4("sim_drain2", 3'd0, 1'b0, 1'b0);

    // Empty: simultaneous push+pop takes only the push
    w4 = 1; r4 = 1; d4 = 1;
    tick();
    w4 = 0; r4 = 0;
    chk4("empty_both", 3'd1, 1'b1, 1'b1);
`ifdef SEMA_ERR_FLAGS_EN
    chk("empty_both_unf", 8'(unf4), 8'd1);
    clr4 = 1; tick(); clr4 = 0;
    chk("unf_clear", 8'(unf4), 8'd0);
`endif
    tick();
    pop4(); chk4("empty_pop_tok", 3'd0, 1'b0, 1'b0);
    pop4(); chk4("empty_pop_drop", 3'd0, 1'b0, 1'b0);
`ifdef SEMA_ERR_FLAGS_EN
    chk("empty_pop_unf", 8'(unf4), 8'd1);
`endif

    // Async reset mid-cycle at occupancy 3
    push4(1); push4(1); push4(1);
    chk4("pre_rst", 3'd3, 1'b1, 1'b1);
    #1;
    rstn = 0;
    #1;
    chk4("async_rst", 3'd0, 1'b0, 1'b0);
    chk("async_rst_data", 8'(q4), 8'd0);
`ifdef SEMA_ERR_FLAGS_EN
    chk("async_rst_unf", 8'(unf4), 8'd0);
`endif
    w4 = 1; r4 = 1; d4 = 1;
    tick(2);
    chk4("in_rst", 3'd0, 1'b0, 1'b0);
    rstn = 1;
    tick();
    // Held requests are new edges: push taken, pop dropped on empty
    chk4("rel_edge", 3'd1, 1'b1, 1'b1);
    tick(3);
    chk4("rel_hold", 3'd1, 1'b1, 1'b1);
    w4 = 0; r4 = 0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/semaphore_channel.md
Name: semaphore_channel

Overview:
- Bit-wide semaphore/mailbox that sits between two CPU cores.
- Producer side is driven by one core's memory_access stage (sema_write / sema_data_out).
- Consumer side feeds the other core's memory_access stage (sema_valid / sema_data_in, acknowledged by sema_ready).
- Holds up to DEPTH single-bit tokens in FIFO order. Accepts CPU handshake signals that stay high for several cycles by acting only on their rising edges.

Parameters:
- DEPTH, 1, token capacity; power of 2, 1..16. DEPTH=1 gives a classic single-slot semaphore.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- prod_sema_write  in  1  producer write request (level, held by CPU)
- prod_sema_data  in  1  token bit to store
- prod_sema_is_empty  out  1  producer may write; high while occupancy < DEPTH
- cons_sema_ready  in  1  consumer acknowledge (level, held by CPU)
- cons_sema_valid  out  1  token available; high while occupancy != 0
- cons_sema_data  out  1  head-of-queue token bit
- occupancy  out  CNT_W  current token count

Behaviour:
- One clock domain. Reset is asynchronous and active-low (rstn); clock is clk. All state is cleared on rstn low, immediately and regardless of clk.
- Reset values:
  - occupancy=0, rd_ptr=0, wr_ptr=0, storage=0.
  - prod_sema_is_empty=1, cons_sema_valid=0, cons_sema_data=0.
  - Edge-detect registers wr_q=0 and rdy_q=0. A request already high when reset releases is therefore seen as a rising edge.
- Edge detection, evaluated every cycle:
  - wr_q<=prod_sema_write; rdy_q<=cons_sema_ready.
  - push_req = prod_sema_write & ~wr_q.
  - pop_req = cons_sema_ready & ~rdy_q.
- Push:
  - Taken if push_req and occupancy<DEPTH, using occupancy at the start of the cycle.
  - On the clock edge: mem[wr_ptr]<=prod_sema_data; wr_ptr increments modulo DEPTH.
  - push_req while full is dropped and never retried. The overflow flag applies only if the optional feature is enabled.
- Pop:
  - Taken if pop_req and occupancy!=0, using start-of-cycle occupancy.
  - rd_ptr increments modulo DEPTH.
  - pop_req while empty is dropped and not remembered.
- Simultaneous push and pop in one cycle:
  - Both are legal when their own conditions hold. Occupancy is unchanged and both pointers advance.
  - Full plus push_req plus pop: pop is taken, push is dropped (start-of-cycle rule).
  - Empty plus push_req plus pop_req: push is taken, pop is dropped.
- Occupancy: +1 on push only, -1 on pop only. Never exceeds DEPTH and never wraps below 0.
- Outputs derived from registered state only (no combinational path from inputs):
  - cons_sema_valid = occupancy!=0.
  - cons_sema_data = mem[rd_ptr].
  - prod_sema_is_empty = occupancy<DEPTH.
- Latency:
  - A push whose rising edge is seen in cycle N is visible on cons_sema_valid/cons_sema_data in cycle N+1.
  - A pop in cycle N updates cons_sema_data to the next token, or drops valid, in cycle N+1.
- Pointer wrap: with DEPTH=1 the pointers are constant 0 and occupancy toggles 0/1.
- Consumer contract: the CPU samples cons_sema_data in the same cycle it sees cons_sema_valid, then raises cons_sema_ready. Data must stay stable until the pop edge.

Optional Feature:
- Macro: SEMA_ERR_FLAGS_EN.
- When defined, adds ports:
  - err_clear  in  1: synchronous clear of both flags; takes priority over a same-cycle set.
  - sema_overflow  out  1: sticky; set on a dropped push_req.
  - sema_underflow  out  1: sticky; set on a dropped pop_req.
- Both flags reset to 0.
- When not defined, these ports and registers are absent. Dropped requests are silent; all other behaviour is identical.

Test Plan:
- Reset, then DEPTH=1: raise prod_sema_write with data=1 and hold it 5 cycles -> exactly one push; cons_sema_valid=1 and cons_sema_data=1 from the next cycle; occupancy=1; prod_sema_is_empty=0.
- Hold cons_sema_ready high 4 cycles after valid -> exactly one pop; valid=0 the next cycle; occupancy=0; is_empty=1. Holding ready longer causes no further pops.
- DEPTH=4: push the sequence 1,0,1,1 (toggle write low between pushes), then a fifth push -> fifth is dropped; occupancy=4; pops return 1,0,1,1 in order; with SEMA_ERR_FLAGS_EN, sema_overflow=1 until err_clear.
- DEPTH=4, occupancy=2: push_req and pop_req rise in the same cycle -> occupancy stays 2; head advances; the new token appears in order after the existing ones. Repeat 6 times to exercise pointer wrap.
- Empty: pop_req rises together with push_req -> occupancy=1, valid=1. pop_req while empty with no push -> no change; sema_underflow=1 if enabled.
- rstn pulled low mid-sequence at occupancy=3, asynchronously between clock edges -> outputs at reset values immediately. Requests still held high at release are each taken as one new edge.
